uart_cmd_decoder: RTL and testbench

Command decoder/executor that sits directly downstream of the UART receiver inside `uart_command_top`. It consumes received bytes (single-cycle `rx_valid` strobes), executes the LED command set (0xA1 ON, 0xA2 OFF, 0xB1 READ, 0xC1 RESET), and returns one response byte per command to the UART transmitter through a start/busy handshake. A one-entry holding register absorbs a byte that arrives while a response is still being sent.

---
 rtl/uart_cmd_pkg.sv | 27 ++
 rtl/uart_cmd_decoder_if.sv | 30 +++
 rtl/uart_byte_hold.sv | 40 ++++
 rtl/uart_cmd_decoder.sv | 156 +++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Opcodes, default response bytes and FSM states for the
//               UART command decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    localparam logic [7:0] CMD_LED_ON  = 8'hA1;
    localparam logic [7:0] CMD_LED_OFF = 8'hA2;
    localparam logic [7:0] CMD_READ    = 8'hB1;
    localparam logic [7:0] CMD_RESET   = 8'hC1;

    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'h06;
    localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXEC      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_HI   = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder_if
// Description : Receiver strobe, transmitter handshake and status outputs of
//               the UART command decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_decoder_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       led;
    logic [7:0] cmd_count;
    logic       overflow;

    modport slave (
        input  rx_data, rx_valid, tx_busy,
        output tx_data, tx_start, led, cmd_count, overflow
    );

    modport master (
        output rx_data, rx_valid, tx_busy,
        input  tx_data, tx_start, led, cmd_count, overflow
    );

endinterface
`default_nettype wire

// File: rtl/uart_byte_hold.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_hold
// Description : One-entry byte holding register; flags a load that finds it
//               full and not being consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_hold (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       load,
    input  wire logic [7:0] load_data,
    input  wire logic       consume,
    output logic            full,
    output logic [7:0]      data,
    output logic            drop
);

    logic       r_full;
    logic [7:0] r_data;

    assign full = r_full;
    assign data = r_data;
    assign drop = load & r_full & ~consume;

    // A consume in the same cycle frees the slot, so the new byte refills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= 8'h00;
        end else if (load && (!r_full || consume)) begin
            r_full <= 1'b1;
            r_data <= load_data;
        end else if (consume) begin
            r_full <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Executes LED commands from received bytes and returns one
//               response byte per command over a start/busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE = DEFAULT_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE = DEFAULT_NAK_BYTE
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_cmd_decoder_if.slave bus
);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cmd, w_cmd_nxt;
    logic [7:0] r_resp, w_resp_nxt;
    logic [7:0] r_tx_data, w_tx_data_nxt;
    logic [7:0] r_count, w_count_nxt;
    logic       r_led, w_led_nxt;
    logic       r_tx_start, w_tx_start_nxt;
    logic       r_ovf, w_ovf_nxt;

    logic       w_idle;
    logic       w_take_direct;
    logic       w_hold_load;
    logic       w_hold_consume;
    logic       w_hold_full;
    logic       w_hold_drop;
    logic [7:0] w_hold_data;

    // A byte arriving in IDLE with nothing held bypasses the holding register.
    assign w_idle         = (r_state == ST_IDLE);
    assign w_take_direct  = w_idle & ~w_hold_full & bus.rx_valid;
    assign w_hold_load    = bus.rx_valid & ~w_take_direct;
    assign w_hold_consume = w_idle & w_hold_full;

    uart_byte_hold u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (w_hold_load),
        .load_data (bus.rx_data),
        .consume   (w_hold_consume),
        .full      (w_hold_full),
        .data      (w_hold_data),
        .drop      (w_hold_drop)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_nxt      = r_cmd;
        w_resp_nxt     = r_resp;
        w_tx_data_nxt  = r_tx_data;
        w_count_nxt    = r_count;
        w_led_nxt      = r_led;
        w_tx_start_nxt = 1'b0;
        w_ovf_nxt      = r_ovf;

        case (r_state)
            ST_IDLE: begin
                if (w_hold_full) begin
                    w_cmd_nxt   = w_hold_data;
                    w_state_nxt = ST_EXEC;
                end else if (bus.rx_valid) begin
                    w_cmd_nxt   = bus.rx_data;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_SEND;
                case (r_cmd)
                    CMD_LED_ON: begin
                        w_led_nxt   = 1'b1;
                        w_count_nxt = r_count + 8'd1;
                        w_resp_nxt  = ACK_BYTE;
                    end
                    CMD_LED_OFF: begin
                        w_led_nxt   = 1'b0;
                        w_count_nxt = r_count + 8'd1;
                        w_resp_nxt  = ACK_BYTE;
                    end
                    CMD_READ: begin
                        w_count_nxt = r_count + 8'd1;
                        w_resp_nxt  = {7'b0, r_led};
                    end
                    CMD_RESET: begin
                        w_led_nxt   = 1'b0;
                        w_count_nxt = 8'd0;
                        w_ovf_nxt   = 1'b0;
                        w_resp_nxt  = ACK_BYTE;
                    end
                    default: begin
                        w_resp_nxt  = NAK_BYTE;
                    end
                endcase
            end
            ST_SEND: begin
                if (!bus.tx_busy) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = r_resp;
                    w_state_nxt    = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A fresh drop outranks a C1 clear landing in the same cycle.
        if (w_hold_drop) begin
            w_ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= 8'h00;
            r_resp     <= 8'h00;
            r_tx_data  <= 8'h00;
            r_count    <= 8'h00;
            r_led      <= 1'b0;
            r_tx_start <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd      <= w_cmd_nxt;
            r_resp     <= w_resp_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_count    <= w_count_nxt;
            r_led      <= w_led_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    assign bus.tx_data   = r_tx_data;
    assign bus.tx_start  = r_tx_start;
    assign bus.led       = r_led;
    assign bus.cmd_count = r_count;
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_decoder
// Description : Directed bench with a response scoreboard and a simple
//               transmitter busy model for uart_cmd_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;
    import uart_cmd_pkg::*;

    localparam int BUSY_CYCLES = 80;
    localparam int WAIT_LIMIT  = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Transmitter model: busy rises the cycle after tx_start.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (bus.tx_start)
            busy_cnt <= BUSY_CYCLES;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    logic       prev_start = 1'b0;
    logic       exp_led    = 1'b0;
    logic [7:0] exp_count  = 8'h00;
    logic       exp_ovf    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference behaviour of one executed command; returns the response byte.
    function automatic logic [7:0] model(input logic [7:0] c);
        case (c)
            CMD_LED_ON:  begin exp_led = 1'b1; exp_count = exp_count + 8'd1; return 8'h06; end
            CMD_LED_OFF: begin exp_led = 1'b0; exp_count = exp_count + 8'd1; return 8'h06; end
            CMD_READ:    begin exp_count = exp_count + 8'd1; return {7'b0, exp_led}; end
            CMD_RESET:   begin exp_led = 1'b0; exp_count = 8'h00; exp_ovf = 1'b0; return 8'h06; end
            default:     return 8'h15;
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus.tx_start) begin
            check("tx_start_while_busy", bus.tx_busy, 0);
            check("tx_start_width", prev_start, 0);
            check("response_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check("tx_data", bus.tx_data, exp_q.pop_front());
        end
        prev_start <= bus.tx_start;
    end

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        exp_q.push_back(model(b));
        strobe(b);
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_q.size() != 0 && k < WAIT_LIMIT) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        while (bus.tx_busy && k < WAIT_LIMIT) begin
            @(negedge clk);
            k++;
        end
        check("wait_in_budget", k < WAIT_LIMIT, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_led"},      bus.led,       exp_led);
        check({tag, "_count"},    bus.cmd_count, exp_count);
        check({tag, "_overflow"}, bus.overflow,  exp_ovf);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_led"},      bus.led,       0);
        check({tag, "_tx_start"}, bus.tx_start,  0);
        check({tag, "_tx_data"},  bus.tx_data,   8'h00);
        check({tag, "_count"},    bus.cmd_count, 8'h00);
        check({tag, "_overflow"}, bus.overflow,  0);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // A1 latency: EXEC cycle still shows old led, effect visible next cycle
        send_cmd(CMD_LED_ON);
        check("a1_exec_led", bus.led, 0);
        @(negedge clk);
        check("a1_n2_led", bus.led, 1);
        check("a1_n2_count", bus.cmd_count, 8'd1);
        wait_done();

        send_cmd(CMD_LED_ON);  wait_done();
        send_cmd(CMD_LED_OFF); wait_done();
        send_cmd(CMD_READ);    wait_done();
        check_outs("seq");

        send_cmd(8'h7F); wait_done();
        check_outs("nak");

        // B1 held and A2 dropped while the A1 response is in flight
        send_cmd(CMD_LED_ON);
        repeat (10) @(negedge clk);
        exp_q.push_back(model(CMD_READ));
        strobe(CMD_READ);
        strobe(CMD_LED_OFF);
        exp_ovf = 1'b1;
        @(negedge clk);
        check("drop_overflow", bus.overflow, 1);
        wait_done();
        repeat (200) @(negedge clk);
        check("no_third_response", exp_q.size(), 0);
        check_outs("held");

        send_cmd(CMD_RESET); wait_done();
        check_outs("c1");

        for (int i = 0; i < 255; i++) begin
            send_cmd(CMD_LED_ON);
            wait_done();
        end
        check("preload_count", bus.cmd_count, 8'd255);
        send_cmd(CMD_READ); wait_done();
        check_outs("wrap");

        // Reset during WAIT_DONE with B1 held
        send_cmd(CMD_LED_ON);
        repeat (10) @(negedge clk);
        strobe(CMD_READ);
        check("pre_rst_led", bus.led, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_led   = 1'b0;
        exp_count = 8'h00;
        exp_ovf   = 1'b0;
        check_reset_values("mid_rst");
        repeat (300) @(negedge clk);
        check("post_rst_no_response", exp_q.size(), 0);
        check_reset_values("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
